// File: rtl/chino_dbus_xbar.sv
// Single-master to NUM_SLAVES data-bus crossbar: address bits [31:28] pick the slave.
// Optional wait-state timeout enabled by defining CHINO_DBUS_TIMEOUT_EN.
module chino_dbus_xbar #(
    parameter int NUM_SLAVES  = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_ce_i,
    input  logic                         m_we_i,
    input  logic [31:0]                  m_addr_i,
    input  logic [3:0]                   m_sel_i,
    input  logic [DATA_W-1:0]            m_data_i,
    output logic [DATA_W-1:0]            m_data_o,
    output logic                         m_stall_o,
    output logic                         m_err_o,
    output logic [NUM_SLAVES-1:0]        s_ce_o,
    output logic                         s_we_o,
    output logic [31:0]                  s_addr_o,
    output logic [3:0]                   s_sel_o,
    output logic [DATA_W-1:0]            s_data_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("chino_dbus_xbar: NUM_SLAVES must be 1..16");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("chino_dbus_xbar: TIMEOUT_CYC must be 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    localparam logic [4:0] NUM_SLAVES_V = 5'(NUM_SLAVES);

    state_t                  state;
    logic   [3:0]            slave_num;
    logic                    in_range;
    logic   [NUM_SLAVES-1:0] slave_oh;
    logic                    ack_hit;
    logic   [DATA_W-1:0]     ack_data;

`ifdef CHINO_DBUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wait_cnt;
`endif

    // s_ce_o holds the one-hot slave select during WAIT, so it doubles as the
    // ack mask and read-data mux select; unselected acks are masked off here.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        slave_num = m_addr_i[31:28];
        in_range  = {1'b0, slave_num} < NUM_SLAVES_V;
        slave_oh  = '0;
        ack_data  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            slave_oh[k] = (slave_num == 4'(k));
            if (s_ce_o[k]) ack_data = ack_data | s_data_i[k*DATA_W +: DATA_W];
        end
        ack_hit = |(s_ack_i & s_ce_o);
    end

    assign m_stall_o = ((state == ST_IDLE) && m_ce_i) || (state == ST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            s_ce_o   <= '0;
            s_we_o   <= 1'b0;
            s_addr_o <= '0;
            s_sel_o  <= '0;
            s_data_o <= '0;
            m_data_o <= '0;
            m_err_o  <= 1'b0;
`ifdef CHINO_DBUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_ce_i) begin
                        if (in_range) begin
                            s_we_o   <= m_we_i;
                            s_addr_o <= m_addr_i;
                            s_sel_o  <= m_sel_i;
                            s_data_o <= m_data_i;
                            s_ce_o   <= slave_oh;
`ifdef CHINO_DBUS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                            state    <= ST_WAIT;
                        end else begin
                            m_data_o <= '0;
                            m_err_o  <= 1'b1;
                            state    <= ST_ERR;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack in the cycle the timeout expires still completes normally.
                    if (ack_hit) begin
                        m_data_o <= s_we_o ? '0 : ack_data;
                        s_ce_o   <= '0;
                        state    <= ST_RESP;
                    end
`ifdef CHINO_DBUS_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            s_ce_o   <= '0;
                            m_data_o <= '0;
                            m_err_o  <= 1'b1;
                            state    <= ST_ERR;
                        end
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    m_err_o <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chino_dbus_xbar.sv
// Directed self-checking bench for chino_dbus_xbar (NUM_SLAVES=4, DATA_W=32, TIMEOUT_CYC=8).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_chino_dbus_xbar;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           m_ce_i;
    logic           m_we_i;
    logic [31:0]    m_addr_i;
    logic [3:0]     m_sel_i;
    logic [DW-1:0]  m_data_i;
    logic [DW-1:0]  m_data_o;
    logic           m_stall_o;
    logic           m_err_o;
    logic [NS-1:0]  s_ce_o;
    logic           s_we_o;
    logic [31:0]    s_addr_o;
    logic [3:0]     s_sel_o;
    logic [DW-1:0]  s_data_o;
    logic [NS*DW-1:0] s_data_i;
    logic [NS-1:0]  s_ack_i;

    int n_checks = 0;
    int n_pass   = 0;

    chino_dbus_xbar #(.NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_ce_i   (m_ce_i),
        .m_we_i   (m_we_i),
        .m_addr_i (m_addr_i),
        .m_sel_i  (m_sel_i),
        .m_data_i (m_data_i),
        .m_data_o (m_data_o),
        .m_stall_o(m_stall_o),
        .m_err_o  (m_err_o),
        .s_ce_o   (s_ce_o),
        .s_we_o   (s_we_o),
        .s_addr_o (s_addr_o),
        .s_sel_o  (s_sel_o),
        .s_data_o (s_data_o),
        .s_data_i (s_data_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic request(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data);
        m_ce_i   = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_sel_i  = sel;
        m_data_i = data;
    endtask

    task automatic drop_request();
        m_ce_i   = 1'b0;
        m_we_i   = 1'b0;
        m_addr_i = '0;
        m_sel_i  = '0;
        m_data_i = '0;
    endtask

    task automatic slave_ack(input int k, input logic [31:0] data);
        s_ack_i = '0;
        s_ack_i[k] = 1'b1;
        s_data_i[k*DW +: DW] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drop_request();
        s_data_i = '0;
        s_ack_i  = '0;
        #12;
        check("rst_stall", m_stall_o, 0);
        check("rst_s_ce", s_ce_o, 0);
        check("rst_err", m_err_o, 0);
        check("rst_data", m_data_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // Read from slave 1, zero-wait ack
        @(negedge clk);
        request(1'b0, 32'h1000_0010, 4'hF, 32'h0);
        #1;
        check("rd_idle_stall", m_stall_o, 1);
        check("rd_idle_s_ce", s_ce_o, 0);
        @(negedge clk);
        check("rd_wait_s_ce", s_ce_o, 4'b0010);
        check("rd_wait_stall", m_stall_o, 1);
        check("rd_wait_addr", s_addr_o, 32'h1000_0010);
        check("rd_wait_we", s_we_o, 0);
        slave_ack(1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rd_resp_stall", m_stall_o, 0);
        check("rd_resp_data", m_data_o, 32'hDEAD_BEEF);
        check("rd_resp_s_ce", s_ce_o, 0);
        check("rd_resp_err", m_err_o, 0);
        drop_request();
        s_ack_i = '0;
        @(negedge clk);
        check("rd_idle_hold", m_data_o, 32'hDEAD_BEEF);
        check("rd_idle_stall2", m_stall_o, 0);

        // Out-of-range slave 5
        request(1'b0, 32'h5000_0000, 4'hF, 32'h0);
        #1;
        check("oor_stall", m_stall_o, 1);
        check("oor_s_ce", s_ce_o, 0);
        @(negedge clk);
        check("oor_err", m_err_o, 1);
        check("oor_stall_err", m_stall_o, 0);
        check("oor_data", m_data_o, 0);
        check("oor_s_ce_err", s_ce_o, 0);
        drop_request();
        @(negedge clk);
        check("oor_err_clear", m_err_o, 0);
        check("oor_idle_s_ce", s_ce_o, 0);

        // Write to slave 0, ack after three wait cycles
        request(1'b1, 32'h0000_0004, 4'b0011, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wr_wait%0d_s_ce", i), s_ce_o, 4'b0001);
            check($sformatf("wr_wait%0d_we", i), s_we_o, 1);
            check($sformatf("wr_wait%0d_sel", i), s_sel_o, 4'b0011);
            check($sformatf("wr_wait%0d_data", i), s_data_o, 32'h1234_5678);
            check($sformatf("wr_wait%0d_stall", i), m_stall_o, 1);
        end
        @(negedge clk);
        check("wr_wait3_s_ce", s_ce_o, 4'b0001);
        slave_ack(0, 32'hAAAA_AAAA);
        @(negedge clk);
        check("wr_resp_stall", m_stall_o, 0);
        check("wr_resp_data", m_data_o, 0);
        check("wr_resp_err", m_err_o, 0);
        drop_request();
        s_ack_i = '0;
        @(negedge clk);

        // Stray ack from slave 2 while slave 1 is selected
        request(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        @(negedge clk);
        slave_ack(2, 32'h2222_2222);
        @(negedge clk);
        check("stray_stall", m_stall_o, 1);
        check("stray_s_ce", s_ce_o, 4'b0010);
        slave_ack(1, 32'h1111_1111);
        @(negedge clk);
        check("stray_resp_data", m_data_o, 32'h1111_1111);
        drop_request();
        s_ack_i = '0;
        @(negedge clk);

        // Reset pulsed during WAIT
        request(1'b0, 32'h2000_0008, 4'hF, 32'h0);
        @(negedge clk);
        check("rstw_s_ce_pre", s_ce_o, 4'b0100);
        #2;
        rst = 1'b0;
        #1;
        check("rstw_s_ce", s_ce_o, 0);
        check("rstw_stall_ce", m_stall_o, 1);
        drop_request();
        #1;
        check("rstw_stall", m_stall_o, 0);
        check("rstw_data", m_data_o, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstw_post%0d_err", i), m_err_o, 0);
            check($sformatf("rstw_post%0d_s_ce", i), s_ce_o, 0);
            check($sformatf("rstw_post%0d_stall", i), m_stall_o, 0);
        end

`ifdef CHINO_DBUS_TIMEOUT_EN
        // Slave 3 never acks: error after eight wait cycles
        request(1'b0, 32'h3000_0000, 4'hF, 32'h0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d_s_ce", i), s_ce_o, 4'b1000);
        end
        @(negedge clk);
        check("to_err", m_err_o, 1);
        check("to_s_ce", s_ce_o, 0);
        check("to_data", m_data_o, 0);
        check("to_stall", m_stall_o, 0);
        drop_request();
        @(negedge clk);
        check("to_err_clear", m_err_o, 0);

        // Ack in the eighth wait cycle wins over the timeout
        request(1'b0, 32'h3000_0000, 4'hF, 32'h0);
        for (int i = 1; i < TO; i++) @(negedge clk);
        @(negedge clk);
        check("to8_s_ce", s_ce_o, 4'b1000);
        slave_ack(3, 32'h3333_3333);
        @(negedge clk);
        check("to8_err", m_err_o, 0);
        check("to8_data", m_data_o, 32'h3333_3333);
        check("to8_stall", m_stall_o, 0);
        drop_request();
        s_ack_i = '0;
        @(negedge clk);
`else
        // Without the timeout, WAIT holds until the slave acks
        request(1'b0, 32'h3000_0000, 4'hF, 32'h0);
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("nto_stall", m_stall_o, 1);
        check("nto_s_ce", s_ce_o, 4'b1000);
        check("nto_err", m_err_o, 0);
        slave_ack(3, 32'h3333_3333);
        @(negedge clk);
        check("nto_data", m_data_o, 32'h3333_3333);
        check("nto_resp_stall", m_stall_o, 0);
        drop_request();
        s_ack_i = '0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chino_dbus_xbar.md
CHINO_DBUS_XBAR -- requirements
Module: chino_dbus_xbar

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of data-bus slaves (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, data width of the master and slave data buses.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum WAIT cycles before a bus error (1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port m_ce_i  input  1  master request valid, held stable while m_stall_o=1.
REQ-007 SHALL have port m_we_i  input  1  master write (1) / read (0).
REQ-008 SHALL have port m_addr_i  input  32  master byte address; bits [31:28] select the slave.
REQ-009 SHALL have port m_sel_i  input  4  master byte-lane select.
REQ-010 SHALL have port m_data_i  input  DATA_W  master write data.
REQ-011 SHALL have port m_data_o  output  DATA_W  read data returned to master.
REQ-012 SHALL have port m_stall_o  output  1  master must hold its request.
REQ-013 SHALL have port m_err_o  output  1  one-cycle bus-error pulse.
REQ-014 SHALL have port s_ce_o  output  NUM_SLAVES  one-hot slave enable.
REQ-015 SHALL have ports s_we_o (1), s_addr_o (32), s_sel_o (4), s_data_o (DATA_W), all outputs, the registered request broadcast to every slave.
REQ-016 SHALL have port s_data_i  input  NUM_SLAVES*DATA_W  slave k read data in bits [k*DATA_W +: DATA_W].
REQ-017 SHALL have port s_ack_i  input  NUM_SLAVES  per-slave completion.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP, ERR.
REQ-019 In IDLE with m_ce_i=1 and m_addr_i[31:28] < NUM_SLAVES, SHALL register we/addr/sel/data and slave index k, and enter WAIT next cycle.
REQ-020 In IDLE with m_ce_i=1 and m_addr_i[31:28] >= NUM_SLAVES, SHALL enter ERR without asserting any s_ce_o bit.
REQ-021 SHALL drive m_stall_o = (IDLE and m_ce_i) or WAIT, combinationally.
REQ-022 SHALL assert s_ce_o[k] only in WAIT; all other bits 0.
REQ-023 In WAIT, on s_ack_i[k]=1, SHALL register s_data_i slice k into m_data_o (reads; writes load 0) and enter RESP.
REQ-024 SHALL ignore s_ack_i bits of non-selected slaves.
REQ-025 RESP SHALL last exactly one cycle with m_stall_o=0, then return to IDLE; minimum request latency is 2 cycles after the first request cycle (zero-wait slave).
REQ-026 ERR SHALL last one cycle with m_err_o=1, m_stall_o=0, m_data_o=0, then return to IDLE.
REQ-027 m_data_o SHALL hold its value until the next RESP or ERR.
REQ-028 The request seen in RESP/ERR cycles SHALL be considered consumed; a new request is sampled only in IDLE.

Reset
REQ-029 On rst=0, SHALL immediately (asynchronously) enter IDLE and clear s_ce_o, m_data_o, m_err_o, the WAIT counter and all registered request fields to 0; m_stall_o then follows REQ-021.
REQ-030 Reset asserted in WAIT SHALL abort the transfer with no RESP/ERR cycle after release.

Configuration
REQ-031 Macro CHINO_DBUS_TIMEOUT_EN defined: a 16-bit counter SHALL clear on WAIT entry, increment each WAIT cycle without ack, and on reaching TIMEOUT_CYC SHALL enter ERR, dropping s_ce_o.
REQ-032 Ack in the same cycle the counter reaches TIMEOUT_CYC SHALL take priority (RESP, no error).
REQ-033 Macro CHINO_DBUS_TIMEOUT_EN undefined: no counter SHALL exist and WAIT SHALL persist until ack.

Verification
REQ-034 Read addr 0x1000_0010, slave 1 acks in first WAIT cycle with 0xDEADBEEF -> s_ce_o=0010 one cycle, m_stall_o high 2 cycles, m_data_o=0xDEADBEEF in RESP.
REQ-035 Write addr 0x0000_0004, sel=0011, data 0x12345678, slave 0 acks after 3 WAIT cycles -> s_we_o=1, s_sel_o=0011, s_data_o=0x12345678 held throughout WAIT, then RESP.
REQ-036 Read addr 0x5000_0000 with NUM_SLAVES=4 -> no s_ce_o, ERR next cycle with m_err_o=1, m_data_o=0.
REQ-037 With CHINO_DBUS_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks -> ERR after 8 WAIT cycles, s_ce_o cleared; ack on cycle 8 instead -> RESP, m_err_o=0.
REQ-038 rst pulsed low during WAIT -> s_ce_o=0 in the same cycle, IDLE after release, no m_err_o pulse; stray s_ack_i[2] while slave 1 selected -> ignored.
